// File: rtl/tag_array_pkg.sv
// Shared types for the tag-array initiator and the multi-way compare logic.
// A tag word is {valid, tag}; tag_hit() is the single definition of a match.
package tag_array_pkg;

  localparam int TAG_W = 9;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } tag_state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_word_t;

  function automatic logic tag_hit(input tag_word_t w, input logic [TAG_W-1:0] tag);
    return w.valid && (w.tag == tag);
  endfunction

endpackage

// File: rtl/tag_array_ctrl.sv
// Single-way tag-array initiator: arbitrates flush/refill/lookup onto one RAM port,
// sweeps the array invalid after reset and on flush, and returns 1-cycle lookup results.
//
// state | meaning
// INIT  | post-reset sweep writing {0,'0} to every set
// IDLE  | serving flush start, refill and lookup (fixed priority in that order)
// FLUSH | explicit invalidation sweep, ack pulsed the cycle after the last set
module tag_array_ctrl
  import tag_array_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_req_i,
  output logic                  lookup_gnt_o,
  input  logic [ADDR_WIDTH-1:0] lookup_set_i,
  input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
  output logic                  lookup_rvalid_o,
  output logic                  lookup_hit_o,
  input  logic                  refill_req_i,
  output logic                  refill_gnt_o,
  input  logic [ADDR_WIDTH-1:0] refill_set_i,
  input  logic [TAG_WIDTH-1:0]  refill_tag_i,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,
  output logic                  tag_req_o,
  output logic                  tag_write_o,
  output logic [ADDR_WIDTH-1:0] tag_addr_o,
  output logic [TAG_WIDTH:0]    tag_wdata_o,
  input  logic [TAG_WIDTH:0]    tag_rdata_i
);

  tag_state_e            state, state_nxt;
  logic [ADDR_WIDTH:0]   cnt, cnt_nxt, cnt_inc;
  logic                  sweep_done;
  logic                  flush_start;
  logic                  ack_set;
  logic                  rvalid_q;
  logic                  ack_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  tag_word_t             rd_word;

  // The extra counter bit flags the last set without comparing against a wrapped value.
  assign cnt_inc    = cnt + (ADDR_WIDTH+1)'(1);
  assign sweep_done = cnt_inc[ADDR_WIDTH];

  // Hold off while a result is in flight, and in the ack cycle while the requester still holds req.
  assign flush_start  = (state == IDLE) && flush_req_i && !rvalid_q && !ack_q;
  assign refill_gnt_o = (state == IDLE) && refill_req_i && !flush_start;
  assign lookup_gnt_o = (state == IDLE) && lookup_req_i && !refill_req_i && !flush_start;

  assign busy_o          = (state != IDLE);
  assign flush_ack_o     = ack_q;
  assign lookup_rvalid_o = rvalid_q;

  always_comb begin
    rd_word.valid = tag_rdata_i[TAG_WIDTH];
    rd_word.tag   = TAG_W'(tag_rdata_i[TAG_WIDTH-1:0]);
    lookup_hit_o  = rvalid_q && tag_hit(rd_word, TAG_W'(tag_q));
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ack_set     = 1'b0;
    tag_req_o   = 1'b0;
    tag_write_o = 1'b0;
    tag_addr_o  = cnt[ADDR_WIDTH-1:0];
    tag_wdata_o = '0;
    case (state)
      INIT, FLUSH: begin
        tag_req_o   = 1'b1;
        tag_write_o = 1'b1;
        cnt_nxt     = cnt_inc;
        if (sweep_done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ack_set   = (state == FLUSH);
        end
      end
      IDLE: begin
        if (flush_start) begin
          // Set 0 is written in the start cycle so the sweep takes exactly 2**ADDR_WIDTH cycles.
          tag_req_o   = 1'b1;
          tag_write_o = 1'b1;
          cnt_nxt     = cnt_inc;
          state_nxt   = FLUSH;
        end else if (refill_gnt_o) begin
          tag_req_o   = 1'b1;
          tag_write_o = 1'b1;
          tag_addr_o  = refill_set_i;
          tag_wdata_o = {1'b1, refill_tag_i};
        end else if (lookup_gnt_o) begin
          tag_req_o  = 1'b1;
          tag_addr_o = lookup_set_i;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rvalid_q <= lookup_gnt_o;
      ack_q    <= ack_set;
      if (lookup_gnt_o) tag_q <= lookup_tag_i;
    end
  end

  flush_req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
    (flush_req_i && !ack_q) |=> flush_req_i);

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Bench for tag_array_ctrl with a behavioural single-port tag RAM.
// Lookup results are checked by a monitor against a queue filled when lookups are granted.
module tb_tag_array_ctrl;

  localparam int AW = 5;
  localparam int TW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lookup_req_i = 1'b0;
  logic          lookup_gnt_o;
  logic [AW-1:0] lookup_set_i = '0;
  logic [TW-1:0] lookup_tag_i = '0;
  logic          lookup_rvalid_o;
  logic          lookup_hit_o;
  logic          refill_req_i = 1'b0;
  logic          refill_gnt_o;
  logic [AW-1:0] refill_set_i = '0;
  logic [TW-1:0] refill_tag_i = '0;
  logic          flush_req_i = 1'b0;
  logic          flush_ack_o;
  logic          busy_o;
  logic          tag_req_o;
  logic          tag_write_o;
  logic [AW-1:0] tag_addr_o;
  logic [TW:0]   tag_wdata_o;
  logic [TW:0]   tag_rdata_i = '0;

  logic [TW:0]   mem [2**AW];
  bit            exp_q[$];
  int            checks = 0;
  int            errors = 0;

  tag_array_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req_i(lookup_req_i), .lookup_gnt_o(lookup_gnt_o),
    .lookup_set_i(lookup_set_i), .lookup_tag_i(lookup_tag_i),
    .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
    .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o),
    .refill_set_i(refill_set_i), .refill_tag_i(refill_tag_i),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o), .busy_o(busy_o),
    .tag_req_o(tag_req_o), .tag_write_o(tag_write_o), .tag_addr_o(tag_addr_o),
    .tag_wdata_o(tag_wdata_o), .tag_rdata_i(tag_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tag_req_o) begin
      if (tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
      else             tag_rdata_i <= mem[tag_addr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && lookup_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 1, 0);
      end else begin
        check("lookup_hit", {31'd0, lookup_hit_o}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic lookup(input logic [AW-1:0] set, input logic [TW-1:0] tag, input bit exp);
    lookup_req_i = 1'b1;
    lookup_set_i = set;
    lookup_tag_i = tag;
    @(negedge clk);
    check("lookup_gnt", lookup_gnt_o, 1);
    if (lookup_gnt_o) exp_q.push_back(exp);
    @(posedge clk); #1;
    lookup_req_i = 1'b0;
  endtask

  task automatic refill(input logic [AW-1:0] set, input logic [TW-1:0] tag);
    refill_req_i = 1'b1;
    refill_set_i = set;
    refill_tag_i = tag;
    @(negedge clk);
    check("refill_gnt", refill_gnt_o, 1);
    @(posedge clk); #1;
    refill_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy, gnt_busy, writes, bad, acks, ack_k;

    // 1: reset values, INIT length, then every set misses
    lookup_req_i = 1'b1;
    @(negedge clk);
    check("rst_busy", busy_o, 1);
    check("rst_rvalid", lookup_rvalid_o, 0);
    check("rst_hit", lookup_hit_o, 0);
    check("rst_ack", flush_ack_o, 0);
    check("rst_lookup_gnt", lookup_gnt_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_busy = 0;
    gnt_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy_o) break;
      n_busy++;
      if (lookup_gnt_o || refill_gnt_o) gnt_busy++;
    end
    check("init_busy_cycles", n_busy, 32);
    check("init_grants_blocked", gnt_busy, 0);
    check("first_lookup_gnt", lookup_gnt_o, 1);
    if (lookup_gnt_o) exp_q.push_back(1'b0);
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) lookup(AW'(i), 9'h000, 1'b0);

    // 2: refill then immediate lookup sees the new tag
    refill(5'd3, 9'h1A5);
    lookup(5'd3, 9'h1A5, 1'b1);
    lookup(5'd3, 9'h1A4, 1'b0);

    // 3: refill wins over lookup; lookup then refill of same set sees old contents
    refill_req_i = 1'b1; refill_set_i = 5'd7; refill_tag_i = 9'h0C3;
    lookup_req_i = 1'b1; lookup_set_i = 5'd7; lookup_tag_i = 9'h0C3;
    @(negedge clk);
    check("simul_refill_gnt", refill_gnt_o, 1);
    check("simul_lookup_gnt", lookup_gnt_o, 0);
    @(posedge clk); #1;
    refill_req_i = 1'b0;
    lookup(5'd7, 9'h0C3, 1'b1);
    refill(5'd7, 9'h055);
    lookup(5'd7, 9'h055, 1'b1);
    lookup(5'd7, 9'h0C3, 1'b0);

    // 4: fill all sets, flush, everything misses
    for (int i = 0; i < 32; i++) refill(AW'(i), TW'(9'h100 + i));
    lookup(5'd0, 9'h100, 1'b1);
    lookup(5'd31, 9'h11F, 1'b1);
    flush_req_i = 1'b1;
    writes = 0; bad = 0; acks = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tag_req_o && tag_write_o) begin
        if (tag_wdata_o !== '0 || tag_addr_o !== AW'(writes)) bad++;
        writes++;
      end
      if (flush_ack_o) begin
        acks++;
        break;
      end
    end
    check("flush_writes", writes, 32);
    check("flush_write_data_addr", bad, 0);
    check("flush_ack_seen", acks, 1);
    @(posedge clk); #1;
    flush_req_i = 1'b0;
    @(negedge clk);
    check("flush_ack_pulse", flush_ack_o, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) lookup(AW'(i), TW'(9'h100 + i), 1'b0);

    // 5: flush requested during INIT acks 64 cycles after release
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush_req_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acks = 0; ack_k = -1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (flush_ack_o) begin
        acks++;
        if (ack_k < 0) ack_k = k;
        @(posedge clk); #1;
        flush_req_i = 1'b0;
      end
    end
    check("init_flush_ack_cycle", ack_k, 64);
    check("init_flush_ack_count", acks, 1);

    // 6: reset in the middle of a flush
    @(posedge clk); #1;
    flush_req_i = 1'b1;
    n_busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_o) n_busy++;
      if (n_busy == 10) break;
    end
    check("flush_started", n_busy, 10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    flush_req_i = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy_o, 1);
    check("midrst_rvalid", lookup_rvalid_o, 0);
    check("midrst_hit", lookup_hit_o, 0);
    check("midrst_ack", flush_ack_o, 0);
    check("midrst_addr", tag_addr_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reinit_addr0", tag_addr_o, 0);
    check("reinit_write", tag_req_o & tag_write_o, 1);
    n_busy = 1; acks = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (busy_o) n_busy++;
      if (flush_ack_o) acks++;
    end
    check("reinit_busy_cycles", n_busy, 32);
    check("reinit_no_ack", acks, 0);
    @(posedge clk); #1;
    lookup(5'd3, 9'h1A5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
